// File: rtl/thread_select_unit.sv
// Per-cycle round-robin fetch-thread scheduler for a 4-thread fetch path.
// Threads with a pending mispredict redirect are served ahead of the plain round-robin.
module thread_select_unit #(
  parameter int NUM_THREADS = 4,
  parameter int THREAD_BITS = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Stall,
  input  logic [NUM_THREADS-1:0] i_thread_enable,
  input  logic [NUM_THREADS-1:0] i_thread_blocked,
  input  logic [2*NUM_THREADS-1:0] i_branch_mispredict,
  output logic [THREAD_BITS-1:0] o_thread_choice,
  output logic                   o_valid,
  output logic                   o_thread_switch,
  output logic [NUM_THREADS-1:0] o_redirect_pending
);

  logic [THREAD_BITS-1:0] choice_q, choice_d;
  logic [THREAD_BITS-1:0] last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   switch_q, switch_d;
  logic [NUM_THREADS-1:0] pend_q, pend_d;

  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] mispredict;
  logic [NUM_THREADS-1:0] pri;
  logic [NUM_THREADS-1:0] req;
  logic [NUM_THREADS-1:0] clr;
  logic                   found;
  logic [THREAD_BITS-1:0] grant;
  logic                   unused_dir;

  // Returns {found, index}: first set bit of req scanning from last+1 upward, wrapping.
  function automatic logic [THREAD_BITS:0] rr_pick(input logic [NUM_THREADS-1:0] r,
                                                   input logic [THREAD_BITS-1:0] last);
    logic [THREAD_BITS:0]   res;
    logic [THREAD_BITS-1:0] idx;
    res = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx = last + THREAD_BITS'(k);
      if (!res[THREAD_BITS] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      mispredict[t] = i_branch_mispredict[2*t];
    end
  end

  assign unused_dir = ^{i_branch_mispredict[7], i_branch_mispredict[5],
                        i_branch_mispredict[3], i_branch_mispredict[1]};

  assign elig = i_thread_enable & ~i_thread_blocked;
  assign pri  = elig & pend_q;
  assign req  = (pri != '0) ? pri : elig;

  always_comb begin
    choice_d = choice_q;
    last_d   = last_q;
    valid_d  = valid_q;
    switch_d = switch_q;
    clr      = '0;
    {found, grant} = rr_pick(req, last_q);
    if (!i_Stall) begin
      if (found) begin
        choice_d   = grant;
        last_d     = grant;
        valid_d    = 1'b1;
        switch_d   = ~valid_q | (grant != choice_q);
        clr[grant] = 1'b1;
      end else begin
        valid_d  = 1'b0;
        switch_d = 1'b0;
      end
    end
    // A redirect arriving in the same cycle as a grant stays pending for a later slot.
    pend_d = (pend_q & ~clr) | mispredict;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      choice_q <= '0;
      last_q   <= THREAD_BITS'(NUM_THREADS - 1);
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      choice_q <= choice_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
      pend_q   <= pend_d;
    end
  end

  assign o_thread_choice    = choice_q;
  assign o_valid            = valid_q;
  assign o_thread_switch    = switch_q;
  assign o_redirect_pending = pend_q;

endmodule

// File: tb/tb_thread_select_unit.sv
// Bench for thread_select_unit: directed scenarios plus random traffic against a reference model.
module tb_thread_select_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] en = 4'h0;
  logic [3:0] blk = 4'h0;
  logic [7:0] bm = 8'h0;
  logic [1:0] choice;
  logic       valid;
  logic       sw;
  logic [3:0] pend;

  int checks = 0;
  int failures = 0;

  int m_choice = 0;
  int m_last = 3;
  int m_valid = 0;
  int m_switch = 0;
  bit m_pend[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  thread_select_unit dut (
    .i_Clk              (clk),
    .i_Reset_n          (rst_n),
    .i_Stall            (stall),
    .i_thread_enable    (en),
    .i_thread_blocked   (blk),
    .i_branch_mispredict(bm),
    .o_thread_choice    (choice),
    .o_valid            (valid),
    .o_thread_switch    (sw),
    .o_redirect_pending (pend)
  );

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scheduler rules applied to the values sampled at this edge.
  task automatic model_step();
    int  grant;
    bit  is_elig[4];
    bit  any_pri;
    grant = -1;
    if (!rst_n) begin
      m_choice = 0; m_last = 3; m_valid = 0; m_switch = 0;
      for (int t = 0; t < 4; t++) m_pend[t] = 0;
      return;
    end
    any_pri = 0;
    for (int t = 0; t < 4; t++) begin
      is_elig[t] = en[t] && !blk[t];
      if (is_elig[t] && m_pend[t]) any_pri = 1;
    end
    if (!stall) begin
      for (int k = 1; k <= 4 && grant < 0; k++) begin
        int t;
        t = (m_last + k) % 4;
        if (is_elig[t] && (!any_pri || m_pend[t])) grant = t;
      end
    end
    for (int t = 0; t < 4; t++) begin
      if (bm[2*t]) m_pend[t] = 1;
      else if (t == grant) m_pend[t] = 0;
    end
    if (!stall) begin
      if (grant >= 0) begin
        m_switch = (!m_valid || grant != m_choice) ? 1 : 0;
        m_choice = grant;
        m_valid  = 1;
        m_last   = grant;
      end else begin
        m_valid  = 0;
        m_switch = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [3:0] e,
                     input logic [3:0] b, input logic [7:0] mp);
    logic [3:0] mpend;
    @(negedge clk);
    rst_n = r; stall = s; en = e; blk = b; bm = mp;
    @(posedge clk);
    model_step();
    #1;
    for (int t = 0; t < 4; t++) mpend[t] = m_pend[t];
    cmp("model_choice", {6'd0, choice}, 8'(m_choice));
    cmp("model_valid",  {7'd0, valid},  8'(m_valid));
    cmp("model_switch", {7'd0, sw},     8'(m_switch));
    cmp("model_pend",   {4'd0, pend},   {4'd0, mpend});
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 4'hF, 4'h0, 8'h00);
    cmp("rst_choice", {6'd0, choice}, 8'd0);
    cmp("rst_valid", {7'd0, valid}, 8'd0);
    cmp("rst_switch", {7'd0, sw}, 8'd0);
    cmp("rst_pend", {4'd0, pend}, 8'd0);

    // All threads eligible: strict rotation from thread 0
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 4'hF, 4'h0, 8'h00);
      cmp("rr_choice", {6'd0, choice}, 8'(i % 4));
      cmp("rr_valid", {7'd0, valid}, 8'd1);
      cmp("rr_switch", {7'd0, sw}, 8'd1);
    end

    // Two enabled threads, then thread 2 blocked
    cyc(0, 0, 4'h5, 4'h0, 8'h00);
    cyc(1, 0, 4'h5, 4'h0, 8'h00);
    cmp("pair_c0", {6'd0, choice}, 8'd0);
    cyc(1, 0, 4'h5, 4'h0, 8'h00);
    cmp("pair_c1", {6'd0, choice}, 8'd2);
    cyc(1, 0, 4'h5, 4'h4, 8'h00);
    cmp("blk_c0", {6'd0, choice}, 8'd0);
    cmp("blk_sw0", {7'd0, sw}, 8'd1);
    cyc(1, 0, 4'h5, 4'h4, 8'h00);
    cmp("blk_c1", {6'd0, choice}, 8'd0);
    cmp("blk_sw1", {7'd0, sw}, 8'd0);

    // Mispredict on thread 3 after a grant to thread 0
    cyc(0, 0, 4'hF, 4'h0, 8'h00);
    cyc(1, 0, 4'hF, 4'h0, 8'h00);
    cmp("mp_first", {6'd0, choice}, 8'd0);
    cyc(1, 0, 4'hF, 4'h0, 8'b0100_0000);
    cmp("mp_pend_set", {4'd0, pend}, 8'h08);
    cyc(1, 0, 4'hF, 4'h0, 8'h00);
    cmp("mp_grant3", {6'd0, choice}, 8'd3);
    cmp("mp_pend_clr", {4'd0, pend}, 8'h00);
    cyc(1, 0, 4'hF, 4'h0, 8'h00);
    cmp("mp_resume", {6'd0, choice}, 8'd0);

    // Stall with a thread-1 redirect arriving mid-stall
    cyc(1, 1, 4'hF, 4'h0, 8'b0000_0100);
    cyc(1, 1, 4'hF, 4'h0, 8'h00);
    cyc(1, 1, 4'hF, 4'h0, 8'h00);
    cmp("stall_choice", {6'd0, choice}, 8'd0);
    cmp("stall_valid", {7'd0, valid}, 8'd1);
    cmp("stall_pend", {4'd0, pend}, 8'h02);
    cyc(1, 0, 4'hF, 4'h0, 8'h00);
    cmp("unstall_grant", {6'd0, choice}, 8'd1);
    cmp("unstall_pend", {4'd0, pend}, 8'h00);

    // Nothing enabled, then thread 2 alone
    cyc(1, 0, 4'h0, 4'h0, 8'h00);
    cyc(1, 0, 4'h0, 4'h0, 8'h00);
    cmp("idle_valid", {7'd0, valid}, 8'd0);
    cmp("idle_switch", {7'd0, sw}, 8'd0);
    cmp("idle_hold", {6'd0, choice}, 8'd1);
    cyc(1, 0, 4'h4, 4'h0, 8'h00);
    cmp("wake_choice", {6'd0, choice}, 8'd2);
    cmp("wake_valid", {7'd0, valid}, 8'd1);
    cmp("wake_switch", {7'd0, sw}, 8'd1);

    // Reset with redirects pending discards them
    cyc(1, 1, 4'hF, 4'h0, 8'b0100_0100);
    cmp("pre_rst_pend", {4'd0, pend}, 8'h0A);
    cyc(0, 0, 4'hF, 4'h0, 8'h00);
    cmp("mid_rst_pend", {4'd0, pend}, 8'h00);
    cmp("mid_rst_valid", {7'd0, valid}, 8'd0);
    cmp("mid_rst_choice", {6'd0, choice}, 8'd0);
    cyc(1, 0, 4'hF, 4'h0, 8'h00);
    cmp("post_rst_grant", {6'd0, choice}, 8'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] mp;
      mp = 8'($urandom);
      if ($urandom_range(0, 3) != 0) mp = mp & 8'hAA;
      cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) == 0),
          4'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), mp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
